instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, meaning the instruction memory capacity in 32-bit words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of the first word written.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-004 Ports SHALL be, clock and reset first:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a program load
- num_words  in  16  words to load, sampled when start is accepted
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  incoming program byte
- byte_ready  out  1  loader accepts byte_data this cycle
- mem_we  out  1  instruction-memory write enable
- mem_addr  out  32  instruction-memory byte address, word aligned
- mem_wdata  out  32  instruction word to write
- busy  out  1  load in progress
- cpu_hold  out  1  hold program counter and fetch while high
- done  out  1  one-cycle pulse at end of a load
- err  out  1  one-cycle pulse, coincident with done, for a rejected load

Function
REQ-005 The FSM SHALL have states IDLE, LOAD, WRITE and FINISH.
REQ-006 In IDLE, start SHALL be accepted; in any other state, start SHALL be ignored.
REQ-007 On accepted start with 1 <= num_words <= DEPTH_WORDS, the block SHALL latch num_words, clear the byte and word counters, and enter LOAD next cycle.
REQ-008 On accepted start with num_words == 0 or num_words > DEPTH_WORDS, the block SHALL enter FINISH, assert err with done, and perform no write.
REQ-009 byte_ready SHALL be 1 only in LOAD; a byte SHALL transfer only on a cycle where byte_valid && byte_ready.
REQ-010 Bytes SHALL pack little-endian: the 1st accepted byte goes to [7:0], the 2nd to [15:8], the 3rd to [23:16] and the 4th to [31:24].
REQ-011 Acceptance of the 4th byte SHALL move the FSM to WRITE on the next cycle.
REQ-012 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_wdata holding the packed word and mem_addr = BASE_ADDR + 4*word_index (32-bit, modulo 2^32).
REQ-013 After WRITE, the FSM SHALL go to FINISH if word_index+1 == latched num_words; otherwise it SHALL increment word_index and return to LOAD.
REQ-014 In FINISH, done SHALL be 1 for one cycle, and the FSM SHALL then return to IDLE.
REQ-015 busy and cpu_hold SHALL be 1 in LOAD, WRITE and FINISH, and 0 in IDLE.
REQ-016 byte_valid while not in LOAD SHALL be ignored and SHALL NOT alter any state.
REQ-017 Gaps in byte_valid SHALL stall packing indefinitely without timeout.
REQ-018 mem_we SHALL be 0 in every state except WRITE, and mem_addr and mem_wdata SHALL hold their last values.
REQ-019 The minimum load time SHALL be 5*num_words + 2 cycles from start to done when byte_valid is held high.

Reset
REQ-020 Reset SHALL force state IDLE and set byte_ready, mem_we, busy, cpu_hold, done and err to 0.
REQ-021 Reset SHALL also set mem_addr, mem_wdata and all counters to 0.
REQ-022 Reset mid-load SHALL discard the partial word, issue no further write, and leave already-written words untouched.
REQ-023 A reset coincident with start SHALL take priority, so the start is lost.

Structure
REQ-024 A shared package SHALL hold the loader_state_t enum, BYTES_PER_WORD = 4 and WORD_W = 32.
REQ-025 One sub-module, byte_packer, SHALL hold the lane counter and the 32-bit shift/pack register.
REQ-026 byte_packer SHALL expose a word_ready pulse and a clear input.

Verification
REQ-027 start with num_words=1, then bytes 13,00,A0,E3 back-to-back -> one mem_we at addr 0x0 with wdata 0xE3A00013; done at cycle 7; err=0.
REQ-028 num_words=3 with 12 bytes -> writes at 0x0, 0x4 and 0x8 in order; cpu_hold high throughout; done once.
REQ-029 num_words=0, then num_words=65 -> done and err both pulse the cycle after start, with no mem_we.
REQ-030 byte_valid toggled randomly, and start pulsed mid-load -> identical words and addresses as with a continuous stream; the second start is ignored.
REQ-031 reset after the 2nd byte of word 1 of num_words=2 -> no write of word 1; all outputs 0; a following load writes from BASE_ADDR.
REQ-032 BASE_ADDR=32'hFFFF_FFFC with num_words=2 -> addresses 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Holds the loader state encoding, word geometry and the address helper.
package instr_mem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        LOAD   = ST_LOAD,
        WRITE  = ST_WRITE,
        FINISH = ST_FINISH
    } loader_state_t;

    // Byte address of a word slot; wraps modulo 2^32.
    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                     input logic [15:0]       idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into 32-bit words.
// The first byte of a word lands in [7:0]; word_ready fires with the last byte.
module byte_packer
    import instr_mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_data,
    output logic              word_ready,
    output logic [WORD_W-1:0] word
);

    localparam int              LANE_W    = $clog2(BYTES_PER_WORD);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    logic [LANE_W-1:0] lane;
    logic [WORD_W-1:0] pack_reg;

    // Shift each accepted byte in from the top so earlier bytes end up in the low lanes.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane     <= '0;
            pack_reg <= '0;
        end else if (accept) begin
            pack_reg <= {byte_data, pack_reg[WORD_W-1:8]};
            lane     <= (lane == LAST_LANE) ? '0 : lane + LANE_W'(1);
        end
    end

    assign word_ready = accept && (lane == LAST_LANE);
    assign word       = {byte_data, pack_reg[WORD_W-1:8]};

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program from a byte stream into instruction memory while holding the CPU.
// Each packed word is written once at BASE_ADDR + 4*index; done (and err on rejection) pulse at the end.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] num_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam logic [16:0] DEPTH_LIMIT = 17'(DEPTH_WORDS);

    loader_state_t     state;
    logic [15:0]       num_latched;
    logic [15:0]       word_index;
    logic              err_flag;
    logic              start_ok;
    logic              bad_count;
    logic              accept;
    logic              last_word;
    logic              word_ready;
    logic [WORD_W-1:0] packed_word;

    assign start_ok  = start && (state == IDLE);
    assign bad_count = (num_words == 16'd0) || ({1'b0, num_words} > DEPTH_LIMIT);
    assign accept    = byte_valid && (state == LOAD);
    assign last_word = (word_index + 16'd1) == num_latched;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .accept     (accept),
        .byte_data  (byte_data),
        .word_ready (word_ready),
        .word       (packed_word)
    );

    // Load sequencer: capture each completed word, write it for one cycle, then move on or finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            num_latched <= '0;
            word_index  <= '0;
            err_flag    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bad_count) begin
                            err_flag <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            num_latched <= num_words;
                            word_index  <= '0;
                            state       <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (word_ready) begin
                        mem_addr  <= word_addr(BASE_ADDR, word_index);
                        mem_wdata <= packed_word;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (last_word) begin
                        state <= FINISH;
                    end else begin
                        word_index <= word_index + 16'd1;
                        state      <= LOAD;
                    end
                end
                FINISH: begin
                    err_flag <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign byte_ready = (state == LOAD);
    assign mem_we     = (state == WRITE);
    assign busy       = (state != IDLE);
    assign cpu_hold   = busy;
    assign done       = (state == FINISH);
    assign err        = done && err_flag;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader.
// A second instance with BASE_ADDR = 0xFFFF_FFFC shares the inputs to exercise address wrap.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_words;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        byte_ready, mem_we, busy, cpu_hold, done, err;
    logic [31:0] mem_addr, mem_wdata;

    logic        w_byte_ready, w_mem_we, w_busy, w_cpu_hold, w_done, w_err;
    logic [31:0] w_mem_addr, w_mem_wdata;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFFC;

    instr_mem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    instr_mem_loader #(.DEPTH_WORDS(64), .BASE_ADDR(WRAP_BASE)) dut_wrap (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (w_byte_ready),
        .mem_we     (w_mem_we),
        .mem_addr   (w_mem_addr),
        .mem_wdata  (w_mem_wdata),
        .busy       (w_busy),
        .cpu_hold   (w_cpu_hold),
        .done       (w_done),
        .err        (w_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [15:0] num;
        logic        bv;
        logic [7:0]  data;
        logic        e_ready;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic st, input logic [15:0] n, input logic bv,
                                input logic [7:0] d, input logic rdy, input logic we,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic bsy, input logic dn, input logic er);
        vec_t v;
        v.start = st; v.num = n; v.bv = bv; v.data = d;
        v.e_ready = rdy; v.e_we = we; v.e_addr = a; v.e_wdata = wd;
        v.e_busy = bsy; v.e_done = dn; v.e_err = er;
        return v;
    endfunction

    function automatic logic [7:0] byte_of(input int i);
        return 8'((i * 29 + 17) & 255);
    endfunction

    function automatic logic [31:0] word_of(input int k);
        return {byte_of(4*k+3), byte_of(4*k+2), byte_of(4*k+1), byte_of(4*k)};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs and returns 1 time unit after the sampling edge.
    task automatic apply_stimulus(input logic st, input logic [15:0] n, input logic bv, input logic [7:0] d);
        start      = st;
        num_words  = n;
        byte_valid = bv;
        byte_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check_output({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check_output({tag, "_we"},    32'(mem_we),     32'd0);
        check_output({tag, "_busy"},  32'(busy),       32'd0);
        check_output({tag, "_hold"},  32'(cpu_hold),   32'd0);
        check_output({tag, "_done"},  32'(done),       32'd0);
        check_output({tag, "_err"},   32'(err),        32'd0);
    endtask

    // Full load of n words; optional random byte_valid gaps and a stray start mid-load.
    task automatic run_load(input int n, input bit gaps, input bit mid_start, input string tag);
        int idx;
        int nwr;
        int w_nwr;
        int cyc;
        int done_cyc;
        int ndone;
        bit hold_ok;
        bit xfer;
        idx = 0; nwr = 0; w_nwr = 0; cyc = 1; done_cyc = 0; ndone = 0; hold_ok = 1'b1;
        apply_stimulus(1'b1, 16'(n), 1'b0, 8'h00);
        for (int c = 0; c < 400; c++) begin
            cyc++;
            if (mem_we) begin
                check_output({tag, "_addr"},  mem_addr,  32'(4 * nwr));
                check_output({tag, "_wdata"}, mem_wdata, word_of(nwr));
                nwr++;
            end
            if (w_mem_we) begin
                check_output({tag, "_wrap_addr"}, w_mem_addr, WRAP_BASE + 32'(4 * w_nwr));
                w_nwr++;
            end
            if (!cpu_hold || !busy) hold_ok = 1'b0;
            if (done) begin
                ndone++;
                done_cyc = cyc;
                check_output({tag, "_err"}, 32'(err), 32'd0);
                break;
            end
            byte_valid = (idx < 4 * n) && (!gaps || ($urandom_range(0, 1) == 1));
            byte_data  = byte_valid ? byte_of(idx) : 8'($urandom);
            start      = mid_start && (c == 6);
            num_words  = start ? 16'd1 : 16'(n);
            xfer       = byte_valid && byte_ready;
            @(posedge clk);
            #1;
            if (xfer) idx++;
        end
        check_output({tag, "_done_seen"}, 32'(ndone), 32'd1);
        check_output({tag, "_writes"},    32'(nwr),   32'(n));
        check_output({tag, "_wrap_writes"}, 32'(w_nwr), 32'(n));
        check_output({tag, "_hold"},      32'(hold_ok), 32'd1);
        if (!gaps) check_output({tag, "_latency"}, 32'(done_cyc), 32'(5 * n + 2));
        apply_stimulus(1'b0, 16'd0, 1'b0, 8'h00);
        check_idle_zero({tag, "_after"});
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("rst");
        check_output("rst_addr",  mem_addr,  32'd0);
        check_output("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        vecs[0]  = mk(0, 16'd0,  1, 8'hFF, 0, 0, 32'h0, 32'h0,          0, 0, 0);
        vecs[1]  = mk(1, 16'd1,  0, 8'h00, 0, 0, 32'h0, 32'h0,          0, 0, 0);
        vecs[2]  = mk(0, 16'd1,  1, 8'h13, 1, 0, 32'h0, 32'h0,          1, 0, 0);
        vecs[3]  = mk(0, 16'd1,  1, 8'h00, 1, 0, 32'h0, 32'h0,          1, 0, 0);
        vecs[4]  = mk(0, 16'd1,  1, 8'hA0, 1, 0, 32'h0, 32'h0,          1, 0, 0);
        vecs[5]  = mk(0, 16'd1,  1, 8'hE3, 1, 0, 32'h0, 32'h0,          1, 0, 0);
        vecs[6]  = mk(0, 16'd1,  0, 8'h00, 0, 1, 32'h0, 32'hE3A0_0013,  1, 0, 0);
        vecs[7]  = mk(0, 16'd1,  0, 8'h00, 0, 0, 32'h0, 32'hE3A0_0013,  1, 1, 0);
        vecs[8]  = mk(1, 16'd0,  0, 8'h00, 0, 0, 32'h0, 32'hE3A0_0013,  0, 0, 0);
        vecs[9]  = mk(0, 16'd0,  0, 8'h00, 0, 0, 32'h0, 32'hE3A0_0013,  1, 1, 1);
        vecs[10] = mk(1, 16'd65, 0, 8'h00, 0, 0, 32'h0, 32'hE3A0_0013,  0, 0, 0);
        vecs[11] = mk(0, 16'd0,  0, 8'h00, 0, 0, 32'h0, 32'hE3A0_0013,  1, 1, 1);
        vecs[12] = mk(1, 16'd64, 0, 8'h00, 0, 0, 32'h0, 32'hE3A0_0013,  0, 0, 0);
        vecs[13] = mk(0, 16'd64, 1, 8'h55, 1, 0, 32'h0, 32'hE3A0_0013,  1, 0, 0);
        vecs[14] = mk(0, 16'd64, 0, 8'h00, 1, 0, 32'h0, 32'hE3A0_0013,  1, 0, 0);

        for (int i = 0; i < 15; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            check_output({t, "_ready"}, 32'(byte_ready), 32'(vecs[i].e_ready));
            check_output({t, "_we"},    32'(mem_we),     32'(vecs[i].e_we));
            check_output({t, "_addr"},  mem_addr,        vecs[i].e_addr);
            check_output({t, "_wdata"}, mem_wdata,       vecs[i].e_wdata);
            check_output({t, "_busy"},  32'(busy),       32'(vecs[i].e_busy));
            check_output({t, "_hold"},  32'(cpu_hold),   32'(vecs[i].e_busy));
            check_output({t, "_done"},  32'(done),       32'(vecs[i].e_done));
            check_output({t, "_err"},   32'(err),        32'(vecs[i].e_err));
            apply_stimulus(vecs[i].start, vecs[i].num, vecs[i].bv, vecs[i].data);
        end

        // Reset from mid-load returns everything to zero.
        reset = 1'b1;
        apply_stimulus(1'b0, 16'd0, 1'b0, 8'h00);
        check_idle_zero("rst2");
        check_output("rst2_addr",  mem_addr,  32'd0);
        check_output("rst2_wdata", mem_wdata, 32'd0);

        // Reset coincident with start: start is lost.
        apply_stimulus(1'b1, 16'd1, 1'b0, 8'h00);
        reset = 1'b0;
        check_output("rst_start_busy", 32'(busy), 32'd0);
        apply_stimulus(1'b0, 16'd1, 1'b1, 8'h11);
        check_output("rst_start_busy2", 32'(busy), 32'd0);
        check_output("rst_start_ready", 32'(byte_ready), 32'd0);

        run_load(3, 1'b0, 1'b0, "load3");
        run_load(2, 1'b0, 1'b0, "load2");
        run_load(3, 1'b1, 1'b1, "gaps3");

        // Reset after the 2nd byte of word 1 of a 2-word load.
        apply_stimulus(1'b1, 16'd2, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 16'd2, 1'b1, byte_of(i));
        check_output("mid_w0_we",   32'(mem_we), 32'd1);
        check_output("mid_w0_addr", mem_addr,    32'd0);
        apply_stimulus(1'b0, 16'd2, 1'b0, 8'h00);
        apply_stimulus(1'b0, 16'd2, 1'b1, byte_of(4));
        apply_stimulus(1'b0, 16'd2, 1'b1, byte_of(5));
        check_output("mid_pre_rst_ready", 32'(byte_ready), 32'd1);
        reset = 1'b1;
        apply_stimulus(1'b0, 16'd2, 1'b1, byte_of(6));
        reset = 1'b0;
        check_idle_zero("mid_rst");
        check_output("mid_rst_addr",  mem_addr,  32'd0);
        check_output("mid_rst_wdata", mem_wdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 16'd2, 1'b1, byte_of(7 + i));
            check_output("mid_rst_no_we", 32'(mem_we), 32'd0);
        end
        run_load(1, 1'b0, 1'b0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
